// File: rtl/trace_lockstep_cmp.sv
// Lockstep trace comparator: buffers a golden and an optimised core trace stream
// in skew FIFOs, compares them pairwise and reports pass or the first failure.
module trace_lockstep_cmp #(
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             ref_valid,
  input  logic [WIDTH-1:0] ref_data,
  input  logic             dut_valid,
  input  logic [WIDTH-1:0] dut_data,
  input  logic             ref_trap,
  input  logic             dut_trap,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [31:0]      match_count,
  output logic [WIDTH-1:0] ref_mis_data,
  output logic [WIDTH-1:0] dut_mis_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_OVERFLOW = 2'd2;
  localparam logic [1:0] FC_LENGTH   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state_q, state_n;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] dut_mem [DEPTH];

  logic [PW:0]   ref_wr_q, ref_rd_q, dut_wr_q, dut_rd_q;
  logic [PW:0]   ref_wr_n, ref_rd_n, dut_wr_n, dut_rd_n;
  logic          ref_seen_q, dut_seen_q, ref_seen_n, dut_seen_n;
  logic [TW-1:0] tmr_q, tmr_n;

  logic [1:0]       fail_code_n;
  logic [31:0]      match_count_n;
  logic [WIDTH-1:0] ref_mis_n, dut_mis_n;
  logic             done_n, pass_n;

  logic             active, running, draining;
  logic             ref_empty, dut_empty, ref_full, dut_full;
  logic             pop, mismatch;
  logic             ref_push, dut_push, ref_ovf, dut_ovf, overflow;
  logic             timeout, length_err, drain_done;
  logic [WIDTH-1:0] ref_head, dut_head;

  // Pointer-based FIFO status; the extra MSB separates full from empty
  always_comb begin
    running   = (state_q == S_RUN);
    draining  = (state_q == S_DRAIN);
    active    = running | draining;
    ref_empty = (ref_wr_q == ref_rd_q);
    dut_empty = (dut_wr_q == dut_rd_q);
    ref_full  = (ref_wr_q[PW-1:0] == ref_rd_q[PW-1:0]) && (ref_wr_q[PW] != ref_rd_q[PW]);
    dut_full  = (dut_wr_q[PW-1:0] == dut_rd_q[PW-1:0]) && (dut_wr_q[PW] != dut_rd_q[PW]);
    ref_head  = ref_mem[ref_rd_q[PW-1:0]];
    dut_head  = dut_mem[dut_rd_q[PW-1:0]];
  end

  // Datapath events for the current cycle
  always_comb begin
    pop        = active && !ref_empty && !dut_empty;
    mismatch   = pop && (ref_head != dut_head);
    ref_ovf    = active && ref_valid && ref_full && !pop;
    dut_ovf    = active && dut_valid && dut_full && !pop;
    overflow   = ref_ovf | dut_ovf;
    ref_push   = active && ref_valid && !ref_ovf;
    dut_push   = active && dut_valid && !dut_ovf;
    ref_seen_n = ref_seen_q | (running & ref_trap);
    dut_seen_n = dut_seen_q | (running & dut_trap);
    timeout    = running && (ref_seen_q | dut_seen_q) && !(ref_seen_n & dut_seen_n)
                 && (tmr_q == TW'(TIMEOUT - 1));
    length_err = timeout
                 | (draining && (ref_empty != dut_empty) && !ref_valid && !dut_valid);
    drain_done = draining && ref_empty && dut_empty && !ref_valid && !dut_valid;
  end

  // Next-state and output logic
  always_comb begin
    state_n       = state_q;
    ref_wr_n      = ref_wr_q;
    ref_rd_n      = ref_rd_q;
    dut_wr_n      = dut_wr_q;
    dut_rd_n      = dut_rd_q;
    tmr_n         = tmr_q;
    fail_code_n   = fail_code;
    match_count_n = match_count;
    ref_mis_n     = ref_mis_data;
    dut_mis_n     = dut_mis_data;

    if (ref_push) ref_wr_n = ref_wr_q + (PW + 1)'(1);
    if (dut_push) dut_wr_n = dut_wr_q + (PW + 1)'(1);
    if (pop) begin
      ref_rd_n = ref_rd_q + (PW + 1)'(1);
      dut_rd_n = dut_rd_q + (PW + 1)'(1);
    end

    if (running && (ref_seen_q | dut_seen_q) && (tmr_q != TW'(TIMEOUT - 1)))
      tmr_n = tmr_q + TW'(1);

    if (pop && !mismatch && (match_count != 32'hFFFF_FFFF))
      match_count_n = match_count + 32'd1;

    case (state_q)
      S_IDLE: if (enable) state_n = S_RUN;
      S_RUN, S_DRAIN: begin
        if (mismatch) begin
          state_n     = S_FAIL;
          fail_code_n = FC_MISMATCH;
          ref_mis_n   = ref_head;
          dut_mis_n   = dut_head;
        end else if (overflow) begin
          state_n     = S_FAIL;
          fail_code_n = FC_OVERFLOW;
        end else if (length_err) begin
          state_n     = S_FAIL;
          fail_code_n = FC_LENGTH;
        end else if (running && ref_seen_n && dut_seen_n) begin
          state_n = S_DRAIN;
        end else if (drain_done) begin
          state_n = S_PASS;
        end
      end
      S_PASS:  state_n = S_PASS;
      S_FAIL:  state_n = S_FAIL;
      default: state_n = S_IDLE;
    endcase

    done_n = (state_n == S_PASS) || (state_n == S_FAIL);
    pass_n = (state_n == S_PASS);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ref_wr_q     <= '0;
      ref_rd_q     <= '0;
      dut_wr_q     <= '0;
      dut_rd_q     <= '0;
      ref_seen_q   <= 1'b0;
      dut_seen_q   <= 1'b0;
      tmr_q        <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_code    <= FC_NONE;
      match_count  <= '0;
      ref_mis_data <= '0;
      dut_mis_data <= '0;
    end else begin
      state_q      <= state_n;
      ref_wr_q     <= ref_wr_n;
      ref_rd_q     <= ref_rd_n;
      dut_wr_q     <= dut_wr_n;
      dut_rd_q     <= dut_rd_n;
      ref_seen_q   <= ref_seen_n;
      dut_seen_q   <= dut_seen_n;
      tmr_q        <= tmr_n;
      done         <= done_n;
      pass         <= pass_n;
      fail_code    <= fail_code_n;
      match_count  <= match_count_n;
      ref_mis_data <= ref_mis_n;
      dut_mis_data <= dut_mis_n;
    end
  end

  // Storage arrays need no reset: pointers alone define validity
  always_ff @(posedge clk) begin
    if (ref_push) ref_mem[ref_wr_q[PW-1:0]] <= ref_data;
    if (dut_push) dut_mem[dut_wr_q[PW-1:0]] <= dut_data;
  end

endmodule

// File: doc/trace_lockstep_cmp.md
TRACE_LOCKSTEP_CMP -- requirements
Module: trace_lockstep_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 36, trace word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, per-stream skew FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles between the first trap and the second trap.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: start comparison from IDLE.
REQ-007 SHALL have ports ref_valid (input, 1 bit) and ref_data (input, WIDTH bits): golden core trace stream.
REQ-008 SHALL have ports dut_valid (input, 1 bit) and dut_data (input, WIDTH bits): optimised core trace stream.
REQ-009 SHALL have ports ref_trap and dut_trap, input, 1 bit each: level trap indications.
REQ-010 SHALL have port done, output, 1 bit: in PASS or FAIL.
REQ-011 SHALL have port pass, output, 1 bit: in PASS.
REQ-012 SHALL have port fail_code, output, 2 bits: 0 none, 1 data mismatch, 2 FIFO overflow, 3 length/timeout.
REQ-013 SHALL have port match_count, output, 32 bits: number of equal pairs compared.
REQ-014 SHALL have ports ref_mis_data and dut_mis_data, output, WIDTH bits each: the first mismatching pair.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, PASS and FAIL; PASS and FAIL are held until reset.
REQ-016 SHALL go IDLE->RUN on the edge where enable=1; in IDLE, valid and trap inputs are ignored.
REQ-017 SHALL, in RUN and DRAIN, push ref_data into the ref FIFO when ref_valid=1, and dut_data into the dut FIFO when dut_valid=1.
REQ-018 SHALL treat an entry written at edge k as visible at the FIFO head in the cycle following edge k.
REQ-019 SHALL, in any cycle where both FIFOs are non-empty, pop both heads and compare all WIDTH bits.
REQ-020 SHALL permit push and pop on a full FIFO in the same cycle; occupancy is unchanged and this is not an overflow.
REQ-021 SHALL, on a push to a full FIFO without a pop, enter FAIL with fail_code=2 at that edge; the word is dropped.
REQ-022 SHALL, on an equal compare, increment match_count at the same edge as the pop; match_count saturates at 0xFFFFFFFF.
REQ-023 SHALL, on an unequal compare, enter FAIL with fail_code=1 at the pop edge and capture both heads into ref_mis_data and dut_mis_data.
REQ-024 SHALL latch each trap as sticky internally; once either is seen, a TIMEOUT-cycle counter starts.
REQ-025 SHALL go RUN->DRAIN when both traps have been seen; if the counter reaches TIMEOUT with only one trap seen, SHALL enter FAIL with fail_code=3.
REQ-026 SHALL, in DRAIN, continue pushes and compares; both FIFOs empty -> PASS; one empty and the other non-empty with no push that cycle -> FAIL with fail_code=3.
REQ-027 SHALL give priority mismatch > overflow > length/timeout when these occur on the same edge; only the first failure is recorded.
REQ-028 SHALL freeze fail_code, mis_data and match_count once in PASS or FAIL.
REQ-029 SHALL use modulo-DEPTH read/write pointers with an extra wrap bit to distinguish full from empty.

Reset
REQ-030 SHALL, while resetn=0, asynchronously force state=IDLE, FIFOs empty, trap flags and timeout counter cleared, and done, pass, fail_code, match_count, ref_mis_data and dut_mis_data all 0.
REQ-031 SHALL, on reset asserted mid-operation, discard all FIFO contents and resume only via enable after release.

Verification (WIDTH=36, DEPTH=4, TIMEOUT=8)
REQ-032 SHALL cover: identical streams 0x1..0x5 with dut lagging 2 cycles, then both traps -> pass=1, match_count=5, fail_code=0.
REQ-033 SHALL cover: 3rd dut word 0x3 replaced by 0x7 -> FAIL, fail_code=1, ref_mis_data=0x3, dut_mis_data=0x7, match_count=2.
REQ-034 SHALL cover: 5 ref words pushed with no dut words -> fail_code=2 on the 5th push edge.
REQ-035 SHALL cover: full FIFO with simultaneous push and pop for 10 cycles of equal data -> no overflow, match_count=10.
REQ-036 SHALL cover: ref_trap with no dut_trap for 8 cycles -> fail_code=3; separately, both traps with 1 ref word left in DRAIN -> fail_code=3.
REQ-037 SHALL cover: resetn pulsed low mid-RUN with 3 entries queued -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
